// File: rtl/pll_lock_reset_ctrl.sv
// PLL lock qualifier: synchronises locked, requires a stable window before releasing sys_rst, holds reset after lock loss.
// Optional lock-loss counter enabled by defining LOCK_LOSS_CNT_EN; otherwise lock_loss_cnt is tied to zero.
module pll_lock_reset_ctrl #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  output logic       sys_rst,
  output logic       ready,
  output logic [7:0] lock_loss_cnt
);

  localparam int MAX_CYC = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    STABLE = 2'd1,
    RUN    = 2'd2,
    HOLD   = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sys_rst_q, sys_rst_d;
  logic                   ready_q, ready_d;

  // Locked synchroniser; only lock_s is visible to the rest of the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // State, shared counter and registered reset/ready outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WAIT;
      cnt_q     <= CNT_ZERO;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state and counter logic; the counter times both the stable window and the hold time.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_ZERO;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = STABLE;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = HOLD;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = RUN;
          cnt_d   = CNT_ZERO;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = WAIT;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = HOLD;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = WAIT;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Outputs decoded from the next state so they change on the same edge as the transition.
  always_comb begin
    sys_rst_d = 1'b1;
    ready_d   = 1'b0;
    if (state_d == RUN) begin
      sys_rst_d = 1'b0;
      ready_d   = 1'b1;
    end else begin
      sys_rst_d = 1'b1;
      ready_d   = 1'b0;
    end
  end

  assign sys_rst = sys_rst_q;
  assign ready   = ready_q;

`ifdef LOCK_LOSS_CNT_EN
  logic [7:0] loss_q, loss_d;
  logic       loss_evt_s;

  assign loss_evt_s = (state_q == RUN) && (state_d == HOLD);

  // Saturating lock-loss count.
  always_comb begin
    loss_d = loss_q;
    if (loss_evt_s && (loss_q != 8'd255)) begin
      loss_d = loss_q + 8'd1;
    end else begin
      loss_d = loss_q;
    end
  end

  // Lock-loss counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loss_q <= 8'd0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign lock_loss_cnt = loss_q;
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
// Randomised and directed bench for pll_lock_reset_ctrl, checked against a run-length reference model.
module tb_pll_lock_reset_ctrl;

  localparam int SYNC   = 2;
  localparam int STABLE = 8;
  localparam int HOLD   = 4;
`ifdef LOCK_LOSS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       sys_rst;
  logic       ready;
  logic [7:0] lock_loss_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: released flag, run of qualifying lock samples, hold time left, loss count.
  bit m_run   = 1'b0;
  int m_ones  = 0;
  int m_hold  = 0;
  int m_loss  = 0;
  int samp_q[$];

  pll_lock_reset_ctrl #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .HOLD_CYCLES  (HOLD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .locked       (locked),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_loss(input int n);
    return CNT_EN ? n : 0;
  endfunction

  // Model: released once STABLE+1 consecutive synchronised-high samples are seen outside the hold time.
  initial begin
    forever begin
      int s;
      @(posedge clk or posedge rst);
      if (rst) begin
        samp_q.delete();
        m_run  = 1'b0;
        m_ones = 0;
        m_hold = 0;
        m_loss = 0;
      end else begin
        s = (samp_q.size() >= SYNC) ? samp_q[samp_q.size() - SYNC] : 0;
        samp_q.push_back(locked ? 1 : 0);
        if (samp_q.size() > 8) void'(samp_q.pop_front());
        if (m_run) begin
          if (s == 0) begin
            m_run  = 1'b0;
            m_hold = HOLD;
            m_ones = 0;
            if (m_loss < 255) m_loss++;
          end
        end else if (m_hold > 0) begin
          m_hold--;
          m_ones = 0;
        end else if (s != 0) begin
          m_ones++;
          if (m_ones == STABLE + 1) begin
            m_run  = 1'b1;
            m_ones = 0;
          end
        end else begin
          m_ones = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("model_sys_rst", 32'(sys_rst), 32'(!m_run));
      chk("model_ready", 32'(ready), 32'(m_run));
      chk("model_loss_cnt", 32'(lock_loss_cnt), 32'(exp_loss(m_loss)));
    end
  end

  // Release reset with locked high; sys_rst must fall exactly at edge SYNC+STABLE+1.
  task automatic clean_lock(input string tag);
    @(negedge clk);
    rst    = 1'b0;
    locked = 1'b1;
    repeat (SYNC + STABLE) @(posedge clk);
    #1;
    chk({tag, "_edge10_sys_rst"}, 32'(sys_rst), 32'd1);
    @(posedge clk);
    #1;
    chk({tag, "_edge11_sys_rst"}, 32'(sys_rst), 32'd0);
    chk({tag, "_edge11_ready"}, 32'(ready), 32'd1);
  endtask

  // Drop locked for one sampled edge, then wait for re-release within a bounded budget.
  task automatic loss_relock(output bit ok);
    int k;
    @(negedge clk);
    locked = 1'b0;
    @(negedge clk);
    locked = 1'b1;
    repeat (3) @(negedge clk);
    k = 0;
    while (!ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    ok = (k < 100);
  endtask

  initial begin
    bit ok;
    int run_left;

    rst    = 1'b1;
    locked = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_sys_rst", 32'(sys_rst), 32'd1);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_loss_cnt", 32'(lock_loss_cnt), 32'd0);

    clean_lock("clean");

    // Lock loss in RUN: one-edge drop.
    @(negedge clk);
    locked = 1'b0;
    @(posedge clk);
    @(negedge clk);
    locked = 1'b1;
    @(posedge clk);
    #1;
    chk("loss_edge2_sys_rst", 32'(sys_rst), 32'd0);
    @(posedge clk);
    #1;
    chk("loss_edge3_sys_rst", 32'(sys_rst), 32'd1);
    chk("loss_edge3_ready", 32'(ready), 32'd0);
    chk("loss_edge3_cnt", 32'(lock_loss_cnt), 32'(exp_loss(1)));
    repeat (12) @(posedge clk);
    #1;
    chk("loss_edge15_sys_rst", 32'(sys_rst), 32'd1);
    @(posedge clk);
    #1;
    chk("loss_edge16_sys_rst", 32'(sys_rst), 32'd0);

    // Sub-cycle glitch never sampled by the synchroniser.
    @(negedge clk);
    locked = 1'b0;
    #2;
    locked = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("glitch_ready", 32'(ready), 32'd1);
    chk("glitch_cnt", 32'(lock_loss_cnt), 32'(exp_loss(1)));

    // Unstable lock: 5 high, 3 low, then high.
    @(negedge clk);
    rst    = 1'b1;
    locked = 1'b0;
    @(negedge clk);
    rst    = 1'b0;
    locked = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    locked = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    locked = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("unstable_edge10_sys_rst", 32'(sys_rst), 32'd1);
    @(posedge clk);
    #1;
    chk("unstable_edge11_sys_rst", 32'(sys_rst), 32'd0);

    // Async reset mid-STABLE (counter at 5).
    @(negedge clk);
    rst    = 1'b1;
    locked = 1'b0;
    @(negedge clk);
    rst    = 1'b0;
    locked = 1'b1;
    repeat (SYNC + 6) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_stable_sys_rst", 32'(sys_rst), 32'd1);
    chk("async_stable_ready", 32'(ready), 32'd0);
    clean_lock("after_stable_rst");

    // Async reset mid-RUN with a non-zero loss count.
    loss_relock(ok);
    chk("pre_async_relock", 32'(ok), 32'd1);
    chk("pre_async_cnt", 32'(lock_loss_cnt), 32'(exp_loss(1)));
    #2;
    rst = 1'b1;
    #1;
    chk("async_run_sys_rst", 32'(sys_rst), 32'd1);
    chk("async_run_ready", 32'(ready), 32'd0);
    chk("async_run_cnt", 32'(lock_loss_cnt), 32'd0);
    clean_lock("after_run_rst");

    // Saturation over 260 loss/relock cycles.
    for (int i = 0; i < 260; i++) begin
      loss_relock(ok);
      if (!ok) begin
        chk("sat_relock_timeout", 32'(ok), 32'd1);
        break;
      end
    end
    chk("sat_cnt", 32'(lock_loss_cnt), 32'(exp_loss(255)));

    // Random lock behaviour with occasional synchronous-time reset pulses.
    run_left = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
      end
      if (run_left == 0) begin
        locked   = ($urandom_range(0, 3) != 0);
        run_left = locked ? $urandom_range(1, 30) : $urandom_range(1, 8);
      end else begin
        run_left--;
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
